// File: rtl/fibo_result_checker.sv
// Snoops data-memory writes into a shadow of NUM_WORDS doublewords and, on a halt rising edge,
// walks the shadow one entry per cycle checking for the Fibonacci sequence 1, 1, 2, 3, ...
module fibo_result_checker #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int IDX_W     = 8,
    parameter int FIRST_IDX = 1,
    parameter int NUM_WORDS = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W-1:0]  fail_idx
);

    localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        SNOOP = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                               halt_q;
    logic [NUM_WORDS-1:0][DATA_W-1:0]   shadow_q;
    logic [NUM_WORDS-1:0]               written_q;
    logic [KW-1:0]                      k_q, k_d;
    logic [DATA_W-1:0]                  e1_q, e1_d, e2_q, e2_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               pass_q, pass_d;
    logic [IDX_W-1:0]                   fail_idx_q, fail_idx_d;

    logic              trig;
    logic [ADDR_W-1:0] word;
    logic              in_rng;
    logic              wr_en;
    logic [KW-1:0]     widx;
    logic [DATA_W-1:0] exp_val;
    logic              mism;
    logic              last;
    logic [31:0]       fail_sum;

    // Write decode: aligned doubleword inside the checked window, only while snooping.
    assign word    = addr >> 3;
    assign in_rng  = (addr[2:0] == 3'd0)
                  && (word >= ADDR_W'(FIRST_IDX))
                  && (word <  ADDR_W'(FIRST_IDX + NUM_WORDS));
    assign wr_en   = (state_q == SNOOP) && mem_rw && in_rng;
    assign widx    = KW'(word - ADDR_W'(FIRST_IDX));

    assign trig     = halt & ~halt_q;
    assign exp_val  = (k_q < KW'(2)) ? DATA_W'(1) : (e1_q + e2_q);
    assign mism     = !written_q[k_q] || (shadow_q[k_q] != exp_val);
    assign last     = (k_q == KW'(NUM_WORDS - 1));
    assign fail_sum = 32'(FIRST_IDX) + 32'(k_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SNOOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SNOOP:   if (trig) state_d = CHECK;
            CHECK:   if (mism || last) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = SNOOP;
        endcase
    end

    // Walk datapath and next values of the registered outputs
    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        k_d        = k_q;
        e1_d       = e1_q;
        e2_d       = e2_q;
        case (state_q)
            SNOOP: begin
                if (trig) begin
                    busy_d = 1'b1;
                    k_d    = '0;
                    e1_d   = DATA_W'(1);
                    e2_d   = DATA_W'(1);
                end
            end
            CHECK: begin
                if (mism) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = 1'b0;
                    fail_idx_d = fail_sum[IDX_W-1:0];
                end else if (last) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = 1'b1;
                    fail_idx_d = '0;
                end else begin
                    k_d  = k_q + KW'(1);
                    e1_d = e2_q;
                    e2_d = exp_val;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q     <= 1'b0;
            k_q        <= '0;
            e1_q       <= DATA_W'(1);
            e2_q       <= DATA_W'(1);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            halt_q     <= halt;
            k_q        <= k_d;
            e1_q       <= e1_d;
            e2_q       <= e2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // Shadow store; a write in the trigger cycle still lands before the walk reads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            written_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (widx == KW'(i)) begin
                    shadow_q[i]  <= mem_data;
                    written_q[i] <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_fibo_result_checker.sv
// Directed bench for fibo_result_checker: fills the shadow over the write bus, pulses halt,
// and checks walk length and pass/fail_idx against hand-computed values.
module tb_fibo_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rw = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] mem_data = '0;
    logic        halt = 1'b0;
    logic        busy, done, pass;
    logic [7:0]  fail_idx;

    int checks = 0;
    int failures = 0;

    // F(1)..F(20), stored at byte address 8*n
    logic [63:0] fib [20] = '{64'd1, 64'd1, 64'd2, 64'd3, 64'd5, 64'd8, 64'd13, 64'd21,
                              64'd34, 64'd55, 64'd89, 64'd144, 64'd233, 64'd377, 64'd610,
                              64'd987, 64'd1597, 64'd2584, 64'd4181, 64'd6765};

    fibo_result_checker dut (
        .clk      (clk),
        .rst      (rst),
        .mem_rw   (mem_rw),
        .addr     (addr),
        .mem_data (mem_data),
        .halt     (halt),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_idx (fail_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; mem_rw = 1'b0; halt = 1'b0;
        @(negedge clk);
        check({tag, "_rst_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_rst_done"}, {63'd0, done}, 64'd0);
        check({tag, "_rst_pass"}, {63'd0, pass}, 64'd0);
        check({tag, "_rst_fidx"}, {56'd0, fail_idx}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        mem_rw = 1'b1; addr = a; mem_data = d;
        @(negedge clk);
        mem_rw = 1'b0;
    endtask

    // Writes F(n) to 8*n for n=1..20, skipping word 'skip' and replacing word 'bad' by 'bad_val'.
    task automatic write_fib(input int skip, input int bad, input logic [63:0] bad_val);
        for (int n = 1; n <= 20; n++) begin
            if (n != skip) wr(64'(8 * n), (n == bad) ? bad_val : fib[n-1]);
        end
    endtask

    // halt must already be set up to rise; counts busy cycles until done.
    task automatic wait_done(input string tag, output int bcnt);
        bcnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            mem_rw = 1'b0;
            if (busy) bcnt++;
            if (done) break;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic run_walk(input string tag, output int bcnt);
        @(negedge clk);
        halt = 1'b1;
        wait_done(tag, bcnt);
        halt = 1'b0;
    endtask

    int bc;

    initial begin
        // Scenario 1: full correct sequence
        do_reset("s1");
        write_fib(0, 0, 64'd0);
        run_walk("s1", bc);
        check("s1_busy_cycles", 64'(bc), 64'd20);
        check("s1_pass", {63'd0, pass}, 64'd1);
        check("s1_fidx", {56'd0, fail_idx}, 64'd0);

        // Scenario 2: word 9 corrupted
        do_reset("s2");
        write_fib(0, 9, 64'd600);
        run_walk("s2", bc);
        check("s2_busy_cycles", 64'(bc), 64'd9);
        check("s2_pass", {63'd0, pass}, 64'd0);
        check("s2_fidx", {56'd0, fail_idx}, 64'd9);

        // Scenario 3: last word never written
        do_reset("s3");
        write_fib(20, 0, 64'd0);
        run_walk("s3", bc);
        check("s3_busy_cycles", 64'(bc), 64'd20);
        check("s3_pass", {63'd0, pass}, 64'd0);
        check("s3_fidx", {56'd0, fail_idx}, 64'd20);

        // Scenario 4: overwrite, misaligned and out-of-range junk
        do_reset("s4");
        wr(64'd40, 64'd99);
        write_fib(0, 0, 64'd0);
        wr(64'd52, 64'hDEAD);
        wr(64'd0, 64'hBEEF);
        wr(64'd168, 64'hCAFE);
        run_walk("s4", bc);
        check("s4_pass", {63'd0, pass}, 64'd1);
        check("s4_fidx", {56'd0, fail_idx}, 64'd0);

        // Scenario 5: last write coincides with halt rise; later halt edges ignored
        do_reset("s5");
        write_fib(20, 0, 64'd0);
        @(negedge clk);
        mem_rw = 1'b1; addr = 64'd160; mem_data = 64'd6765; halt = 1'b1;
        wait_done("s5", bc);
        check("s5_busy_cycles", 64'(bc), 64'd20);
        check("s5_pass", {63'd0, pass}, 64'd1);
        repeat (3) @(negedge clk);
        halt = 1'b0;
        @(negedge clk);
        halt = 1'b1;
        bc = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        halt = 1'b0;
        check("s5_rewalk_busy", 64'(bc), 64'd0);
        check("s5_done_held", {63'd0, done}, 64'd1);
        check("s5_pass_held", {63'd0, pass}, 64'd1);

        // Scenario 6: reset in the middle of the walk, then a clean rerun
        do_reset("s6");
        write_fib(0, 0, 64'd0);
        @(negedge clk);
        halt = 1'b1;
        bc = 0;
        for (int c = 0; c < 50 && bc < 5; c++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("s6_walk_started", 64'(bc), 64'd5);
        #1 rst = 1'b1;
        #1;
        check("s6_abort_busy", {63'd0, busy}, 64'd0);
        check("s6_abort_done", {63'd0, done}, 64'd0);
        check("s6_abort_pass", {63'd0, pass}, 64'd0);
        check("s6_abort_fidx", {56'd0, fail_idx}, 64'd0);
        halt = 1'b0;
        do_reset("s6b");
        // shadow must be cleared by reset: a walk without writes fails at word 1
        run_walk("s6c", bc);
        check("s6c_pass", {63'd0, pass}, 64'd0);
        check("s6c_fidx", {56'd0, fail_idx}, 64'd1);
        do_reset("s6d");
        write_fib(0, 0, 64'd0);
        run_walk("s6d", bc);
        check("s6d_busy_cycles", 64'(bc), 64'd20);
        check("s6d_pass", {63'd0, pass}, 64'd1);
        check("s6d_fidx", {56'd0, fail_idx}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
